// File: rtl/adder_pkg.sv
// adder_pkg: shared opcodes and segment sizing for the pipelined ripple-carry adder
package adder_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int seg_width(input int width, input int stages);
    return (stages < 1) ? width : width / stages;
  endfunction
endpackage

// File: rtl/rca_pipe_if.sv
// rca_pipe_if: operand and result handshake bundle for rca_pipe
interface rca_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, ci, op, out_ready,
    input  in_ready, out_valid, s, co, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, ci, op, out_ready,
    output in_ready, out_valid, s, co, ovf, zero
  );
endinterface

// File: rtl/rca_seg.sv
// rca_seg: combinational W-bit ripple-carry adder segment
module rca_seg #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic c;

  // Chain one full-adder cell per bit, carry rippling from LSB to MSB
  always_comb begin
    c = ci;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

// File: rtl/rca_pipe.sv
// rca_pipe: pipelined ripple-carry add/sub with registered carry per segment and valid/ready flow control
module rca_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic       clk,
  input logic       reset_n,
  rca_pipe_if.slave bus
);
  localparam int SEG = seg_width(WIDTH, STAGES);

  if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_chk
    $error("rca_pipe: WIDTH must be a multiple of STAGES and STAGES must be at least 1");
  end

  logic             adv;
  logic             ovf_n;
  logic             zero_n;
  logic             ovf_q;
  logic             zero_q;
  logic             pv    [0:STAGES];
  logic             pc    [0:STAGES];
  logic [WIDTH-1:0] ps    [0:STAGES];
  logic [WIDTH-1:0] pa    [0:STAGES-1];
  logic [WIDTH-1:0] pb    [0:STAGES-1];
  logic [WIDTH-1:0] sum_n [1:STAGES];
  logic [SEG-1:0]   seg_s [1:STAGES];
  logic             seg_co[1:STAGES];

  assign adv           = !pv[STAGES] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = pv[STAGES];
  assign bus.s         = ps[STAGES];
  assign bus.co        = pc[STAGES];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

  for (genvar k = 1; k <= STAGES; k++) begin : g_seg
    rca_seg #(.W(SEG)) u_seg (
      .a  (pa[k-1][k*SEG-1 -: SEG]),
      .b  (pb[k-1][k*SEG-1 -: SEG]),
      .ci (pc[k-1]),
      .s  (seg_s[k]),
      .co (seg_co[k])
    );
  end

  // Splice each stage's fresh segment sum into the partial result handed on by the previous stage
  always_comb begin
    for (int k = 1; k <= STAGES; k++) begin
      sum_n[k] = ps[k-1];
      sum_n[k][k*SEG-1 -: SEG] = seg_s[k];
    end
  end

  assign ovf_n  = (pa[STAGES-1][WIDTH-1] == pb[STAGES-1][WIDTH-1]) &&
                  (sum_n[STAGES][WIDTH-1] != pa[STAGES-1][WIDTH-1]);
  assign zero_n = sum_n[STAGES] == '0;

  // Shift every stage forward one slot whenever the output side can make room; b is pre-inverted for subtract
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= STAGES; k++) begin
        pv[k] <= 1'b0;
        pc[k] <= 1'b0;
        ps[k] <= '0;
      end
      for (int k = 0; k < STAGES; k++) begin
        pa[k] <= '0;
        pb[k] <= '0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      pv[0] <= bus.in_valid;
      pa[0] <= bus.a;
      pb[0] <= bus.b ^ {WIDTH{bus.op == OP_SUB}};
      pc[0] <= (bus.op == OP_SUB) ? 1'b1 : bus.ci;
      ps[0] <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        pv[k] <= pv[k-1];
        pc[k] <= seg_co[k];
        ps[k] <= sum_n[k];
      end
      for (int k = 1; k < STAGES; k++) begin
        pa[k] <= pa[k-1];
        pb[k] <= pb[k-1];
      end
      ovf_q  <= ovf_n;
      zero_q <= zero_n;
    end
  end
endmodule

// File: tb/tb_rca_pipe.sv
// tb_rca_pipe: directed and randomized checks of rca_pipe against an arithmetic reference model
module tb_rca_pipe;
  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ovf;
    logic        zero;
    int          due;
  } exp_t;

  localparam int SW [3] = '{8, 16, 64};
  localparam int SS [3] = '{1, 8, 2};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sw_rst_n;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          sw_done [3];
  exp_t        mq [$];
  logic [31:0] prev_s;
  bit          hold_prev;
  int          n_push, n_pop, run, max_run;

  always #5 clk = ~clk;

  rca_pipe_if #(.WIDTH(32)) m ();
  rca_pipe #(.WIDTH(32), .STAGES(4)) dut (.clk(clk), .reset_n(rst_n), .bus(m));

  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic ci, input logic op);
    exp_t r;
    logic [63:0] mask, bb;
    logic [64:0] full;
    logic signed [66:0] sa, sb, t, lim;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = a & mask;
    b = b & mask;
    bb = op ? (~b & mask) : b;
    full = {1'b0, a} + {1'b0, bb} + 65'(op ? 1'b1 : ci);
    r.s = full[63:0] & mask;
    r.co = full[w];
    r.zero = (r.s == 64'd0);
    lim = 67'sd1 <<< (w - 1);
    sa = $signed({3'b000, a}) - (a[w-1] ? (lim <<< 1) : 67'sd0);
    sb = $signed({3'b000, b}) - (b[w-1] ? (lim <<< 1) : 67'sd0);
    t = op ? sa - sb : sa + sb + $signed({66'd0, ci});
    r.ovf = (t >= lim) || (t < -lim);
    r.due = 0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit iv, input bit ordy, input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input logic op);
    exp_t e;
    m.in_valid = iv;
    m.out_ready = ordy;
    m.a = a;
    m.b = b;
    m.ci = ci;
    m.op = op;
    #1;
    if (hold_prev) begin
      check("hold_valid", 64'(m.out_valid), 1);
      check("hold_s", 64'(m.s), 64'(prev_s));
    end
    hold_prev = m.out_valid && !ordy;
    prev_s = m.s;
    run = m.out_valid ? run + 1 : 0;
    if (run > max_run) max_run = run;
    if (m.out_valid && ordy) begin
      check("spurious", 64'(mq.size() > 0), 1);
      if (mq.size() > 0) begin
        e = mq.pop_front();
        n_pop++;
        check("s", 64'(m.s), e.s);
        check("co", 64'(m.co), 64'(e.co));
        check("ovf", 64'(m.ovf), 64'(e.ovf));
        check("zero", 64'(m.zero), 64'(e.zero));
      end
    end
    if (iv && m.in_ready) begin
      mq.push_back(model(32, 64'(a), 64'(b), ci, op));
      n_push++;
    end
    @(negedge clk);
  endtask

  task automatic lat_beat(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic op, input logic [31:0] es,
                          input logic eco, input logic eovf, input logic ez);
    step(1, 1, a, b, ci, op);
    repeat (4) begin
      check({tag, "_early"}, 64'(m.out_valid), 0);
      step(0, 1, 0, 0, 0, 0);
    end
    check({tag, "_valid"}, 64'(m.out_valid), 1);
    check({tag, "_s"}, 64'(m.s), 64'(es));
    check({tag, "_co"}, 64'(m.co), 64'(eco));
    check({tag, "_ovf"}, 64'(m.ovf), 64'(eovf));
    check({tag, "_zero"}, 64'(m.zero), 64'(ez));
    repeat (2) step(0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    sw_rst_n = 1'b1;
    #1 sw_rst_n = 1'b0;
    #20 sw_rst_n = 1'b1;
  end

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int W = SW[g];
    localparam int S = SS[g];
    rca_pipe_if #(.WIDTH(W)) bus ();
    rca_pipe #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .reset_n(sw_rst_n), .bus(bus));
    exp_t        q [$];
    exp_t        e;
    bit          hit, iv;
    logic [63:0] ra, rb;
    logic        ci, op;

    initial begin
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.ci = 1'b0;
      bus.op = 1'b0;
      bus.out_ready = 1'b1;
      #30;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        #1;
        hit = q.size() > 0 && q[0].due == c;
        check($sformatf("w%0d_valid_c%0d", W, c), 64'(bus.out_valid), 64'(hit));
        if (hit) begin
          e = q.pop_front();
          check($sformatf("w%0d_s", W), 64'(bus.s), e.s);
          check($sformatf("w%0d_co", W), 64'(bus.co), 64'(e.co));
          check($sformatf("w%0d_ovf", W), 64'(bus.ovf), 64'(e.ovf));
          check($sformatf("w%0d_zero", W), 64'(bus.zero), 64'(e.zero));
        end
        iv = c < 180 && $urandom_range(0, 3) != 0;
        ra = {$urandom, $urandom};
        rb = ($urandom_range(0, 7) == 0) ? ~ra : {$urandom, $urandom};
        ci = 1'($urandom);
        op = 1'($urandom);
        bus.in_valid = iv;
        bus.a = ra[W-1:0];
        bus.b = rb[W-1:0];
        bus.ci = ci;
        bus.op = op;
        if (iv) begin
          e = model(W, ra, rb, ci, op);
          e.due = c + S + 1;
          q.push_back(e);
        end
      end
      check($sformatf("w%0d_drained", W), 64'(q.size()), 0);
      sw_done[g] = 1'b1;
    end
  end

  initial begin
    hold_prev = 1'b0;
    n_push = 0;
    n_pop = 0;
    run = 0;
    max_run = 0;
    m.in_valid = 1'b0;
    m.out_ready = 1'b1;
    m.a = '0;
    m.b = '0;
    m.ci = 1'b0;
    m.op = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(m.out_valid), 0);
    check("rst_s", 64'(m.s), 0);
    check("rst_co", 64'(m.co), 0);
    check("rst_ovf", 64'(m.ovf), 0);
    check("rst_zero", 64'(m.zero), 0);
    check("rst_in_ready", 64'(m.in_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    lat_beat("t1", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    lat_beat("t2a", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    lat_beat("t2b", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    run = 0;
    max_run = 0;
    for (int i = 0; i < 8; i++) step(1, 1, $urandom, $urandom, 1'($urandom), 1'($urandom));
    repeat (8) step(0, 1, 0, 0, 0, 0);
    check("t3_consecutive", 64'(max_run), 8);
    check("t3_count", 64'(n_pop), 64'(n_push));

    for (int i = 0; i < 6; i++) step(1, 1, $urandom, $urandom, 1'($urandom), 1'($urandom));
    step(1, 0, $urandom, $urandom, 1'($urandom), 1'($urandom));
    check("t4_in_ready", 64'(m.in_ready), 0);
    repeat (2) step(1, 0, $urandom, $urandom, 1'($urandom), 1'($urandom));
    repeat (10) step(0, 1, 0, 0, 0, 0);
    check("t4_no_loss", 64'(n_pop), 64'(n_push));
    check("t4_empty", 64'(mq.size()), 0);

    for (int i = 0; i < 6; i++) step(1, 1, $urandom, $urandom, 1'($urandom), 1'($urandom));
    m.in_valid = 1'b0;
    check("t5_pre_valid", 64'(m.out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("t5_valid", 64'(m.out_valid), 0);
    check("t5_s", 64'(m.s), 0);
    check("t5_co", 64'(m.co), 0);
    check("t5_ovf", 64'(m.ovf), 0);
    check("t5_zero", 64'(m.zero), 0);
    check("t5_in_ready", 64'(m.in_ready), 1);
    mq.delete();
    n_push = n_pop;
    hold_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0, 0, 0);
      check("t5_quiet", 64'(m.out_valid), 0);
    end
    step(1, 1, $urandom, $urandom, 1'($urandom), 1'($urandom));
    repeat (7) step(0, 1, 0, 0, 0, 0);
    check("t5_resume", 64'(n_pop), 64'(n_push));

    for (int i = 0; i < 2000 && !(sw_done[0] && sw_done[1] && sw_done[2]); i++) @(negedge clk);
    check("sweep_done", 64'({sw_done[0], sw_done[1], sw_done[2]}), 64'(3'b111));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
